// File: rtl/gate_box_tester.sv
// Hardware truth-table sweeper for the two-input gate box.
// Drives all four a/b vectors, samples resp after a settle delay, logs mismatches.
module gate_box_tester #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [5:0] resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [3:0] fail_vec,
  output logic [4:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        a_d, b_d, busy_d, done_d, pass_d;
  logic [5:0]  mask_d;
  logic [3:0]  fvec_d;
  logic [4:0]  ecnt_d;
  logic [5:0]  expct;
  logic [5:0]  mism;
  logic [1:0]  idx_nx;

  function automatic logic [5:0] ideal(input logic va, input logic vb);
    ideal = {~(va ^ vb), va ^ vb, ~(va | vb),
             ~(va & vb), va | vb, va & vb};
  endfunction

  function automatic logic [2:0] popcnt(input logic [5:0] v);
    popcnt = 3'd0;
    for (int i = 0; i < 6; i++)
      popcnt = popcnt + 3'(v[i]);
  endfunction

  assign expct  = ideal(idx_q[1], idx_q[0]);
  assign mism   = resp ^ expct;
  assign idx_nx = idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_mask  <= '0;
      fail_vec  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      a         <= a_d;
      b         <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_mask  <= mask_d;
      fail_vec  <= fvec_d;
      err_count <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a;
    b_d     = b;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    mask_d  = err_mask;
    fvec_d  = fail_vec;
    ecnt_d  = err_count;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = '0;
          fvec_d  = '0;
          ecnt_d  = '0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) begin
          cnt_d  = 4'd0;
          mask_d = err_mask | mism;
          ecnt_d = err_count + 5'(popcnt(mism));
          if (|mism)
            fvec_d[idx_q] = 1'b1;
          if (idx_q != 2'd3) begin
            idx_d = idx_nx;
            a_d   = idx_nx[1];
            b_d   = idx_nx[0];
          end else begin
            // Final vector: pass reflects the mask including this sample.
            state_d = S_DONE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mask_d == 6'd0);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_box_tester.sv
// Directed bench for gate_box_tester: settle 1 and settle 3 instances
// against a behavioural gate box with injectable faults.
module tb_gate_box_tester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       a1, b1, busy1, done1, pass1;
  logic [5:0] resp1, mask1;
  logic [3:0] fv1;
  logic [4:0] ec1;

  logic       a3, b3, busy3, done3, pass3;
  logic [5:0] resp3, mask3;
  logic [3:0] fv3;
  logic [4:0] ec3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] gbox(input logic va, input logic vb);
    gbox = {~(va ^ vb), va ^ vb, ~(va | vb),
            ~(va & vb), va | vb, va & vb};
  endfunction

  always_comb begin
    resp1 = gbox(a1, b1);
    if (mode == 2'd1) resp1[4] = 1'b0;
    if (mode == 2'd2) resp1 = 6'b111111;
  end

  assign resp3 = gbox(a3, b3);

  gate_box_tester #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(mask1), .fail_vec(fv1), .err_count(ec1)
  );

  gate_box_tester #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a(a3), .b(b3), .resp(resp3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(mask3), .fail_vec(fv3), .err_count(ec3)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl1 got %b want 00000",
               {a1, b1, busy1, done1, pass1});
    end
    n_checks++;
    if ({mask1, fv1, ec1} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_res1 got %h want 0", {mask1, fv1, ec1});
    end
    n_checks++;
    if ({a3, b3, busy3, done3, pass3, mask3, fv3, ec3} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_dut3 got %h want 0",
               {a3, b3, busy3, done3, pass3, mask3, fv3, ec3});
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_rst busy=%b done=%b want 0 0",
               busy1, done1);
    end
  endtask

  task automatic run_sweep1(input string nm, input logic [5:0] m,
                            input logic [3:0] fv, input logic [4:0] ec);
    logic xp;
    xp = (m == 6'd0);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
    n_checks++;
    if ({busy1, a1, b1} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_v0 busy,a,b got %b want 100", nm, {busy1, a1, b1});
    end
    n_checks++;
    if ({pass1, mask1, ec1} !== 12'd0) begin
      n_fail++;
      $display("FAIL %s_clear got %h want 0", nm, {pass1, mask1, ec1});
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk) #1;
      n_checks++;
      if ({busy1, done1, a1, b1} !== {2'b10, 2'(i)}) begin
        n_fail++;
        $display("FAIL %s_v%0d busy,done,a,b got %b want %b",
                 nm, i, {busy1, done1, a1, b1}, {2'b10, 2'(i)});
      end
    end
    @(posedge clk) #1;
    n_checks++;
    if ({done1, busy1, a1, b1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s_done done,busy,a,b got %b want 1000",
               nm, {done1, busy1, a1, b1});
    end
    n_checks++;
    if (pass1 !== xp) begin
      n_fail++;
      $display("FAIL %s_pass got %b want %b", nm, pass1, xp);
    end
    n_checks++;
    if (mask1 !== m) begin
      n_fail++;
      $display("FAIL %s_mask got %b want %b", nm, mask1, m);
    end
    n_checks++;
    if (fv1 !== fv) begin
      n_fail++;
      $display("FAIL %s_failvec got %b want %b", nm, fv1, fv);
    end
    n_checks++;
    if (ec1 !== ec) begin
      n_fail++;
      $display("FAIL %s_count got %0d want %0d", nm, ec1, ec);
    end
    @(posedge clk) #1;
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || mask1 !== m || ec1 !== ec) begin
      n_fail++;
      $display("FAIL %s_hold done=%b busy=%b mask=%b cnt=%0d want 0 0 %b %0d",
               nm, done1, busy1, mask1, ec1, m, ec);
    end
  endtask

  task automatic test_ideal();
    mode = 2'd0;
    run_sweep1("ideal", 6'b000000, 4'b0000, 5'd0);
  endtask

  task automatic test_xor_stuck();
    mode = 2'd1;
    run_sweep1("xor0", 6'b010000, 4'b0110, 5'd2);
    mode = 2'd0;
  endtask

  task automatic test_all_ones();
    mode = 2'd2;
    run_sweep1("ones", 6'b111111, 4'b1111, 5'd12);
    mode = 2'd0;
  endtask

  task automatic test_settle3();
    int bc;
    bc = 0;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk) #1 start3 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      n_checks++;
      if ({done3, a3, b3} !== {1'b0, 2'(j / 3)}) begin
        n_fail++;
        $display("FAIL s3_hold%0d done,a,b got %b want %b",
                 j, {done3, a3, b3}, {1'b0, 2'(j / 3)});
      end
      if (busy3 === 1'b1) bc++;
      @(posedge clk) #1;
    end
    n_checks++;
    if (bc != 12) begin
      n_fail++;
      $display("FAIL s3_busy_len got %0d want 12", bc);
    end
    n_checks++;
    if ({done3, busy3, pass3, mask3, ec3} !== {3'b101, 11'd0}) begin
      n_fail++;
      $display("FAIL s3_done got %b want %b",
               {done3, busy3, pass3, mask3, ec3}, {3'b101, 11'd0});
    end
    @(posedge clk) #1;
    n_checks++;
    if (done3 !== 1'b0) begin
      n_fail++;
      $display("FAIL s3_pulse got %b want 0", done3);
    end
  endtask

  task automatic test_abort();
    mode = 2'd1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk) #1 start1 = 1'b0;
    n_checks++;
    if ({busy1, a1, b1, ec1} !== {3'b101, 5'd0}) begin
      n_fail++;
      $display("FAIL abort_ignore busy,a,b,cnt got %b want %b",
               {busy1, a1, b1, ec1}, {3'b101, 5'd0});
    end
    @(posedge clk) #1;
    n_checks++;
    if ({busy1, a1, b1, ec1} !== {3'b110, 5'd1}) begin
      n_fail++;
      $display("FAIL abort_v2 busy,a,b,cnt got %b want %b",
               {busy1, a1, b1, ec1}, {3'b110, 5'd1});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a1, b1, busy1, done1, pass1, mask1, fv1, ec1} !== 20'd0) begin
      n_fail++;
      $display("FAIL abort_rst got %h want 0",
               {a1, b1, busy1, done1, pass1, mask1, fv1, ec1});
    end
    mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk) #1;
      n_checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle%0d done=%b busy=%b want 0 0",
                 j, done1, busy1);
      end
    end
    run_sweep1("after_abort", 6'b000000, 4'b0000, 5'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk) begin
      mode   = 2'd1;
      start1 = 1'b1;
    end
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(posedge clk) #1;
    n_checks++;
    if ({done1, pass1, mask1, fv1, ec1} !== {2'b10, 6'b010000, 4'b0110, 5'd2}) begin
      n_fail++;
      $display("FAIL b2b_first got %b want %b", {done1, pass1, mask1, fv1, ec1},
               {2'b10, 6'b010000, 4'b0110, 5'd2});
    end
    mode = 2'd0;
    @(posedge clk) #1;
    n_checks++;
    if ({done1, busy1, pass1, a1, b1, mask1, fv1, ec1} !== {3'b010, 17'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart got %b want %b",
               {done1, busy1, pass1, a1, b1, mask1, fv1, ec1}, {3'b010, 17'd0});
    end
    repeat (3) @(posedge clk);
    @(posedge clk) #1 start1 = 1'b0;
    n_checks++;
    if ({done1, busy1, pass1, mask1, fv1, ec1} !== {3'b101, 15'd0}) begin
      n_fail++;
      $display("FAIL b2b_second got %b want %b",
               {done1, busy1, pass1, mask1, fv1, ec1}, {3'b101, 15'd0});
    end
    @(posedge clk) #1;
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle done=%b busy=%b want 0 0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_xor_stuck();
    test_all_ones();
    test_settle3();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_box_tester.md
# gate_box_tester

Synthesizable self-checking sweeper for the two-input gate box. On a start pulse it drives all four input combinations onto the gate box `a`/`b` pins, samples the six gate outputs after a settle delay, and compares each against the ideal truth table. It accumulates per-gate and per-vector mismatch records plus a pass flag. It sits beside the gate box on the lab board, so the truth-table sweep runs in hardware instead of only in simulation.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock (single clock domain)
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  sweep request; sampled only in IDLE or DONE
- `a`  out  1  gate box input A, registered
- `b`  out  1  gate box input B, registered
- `resp`  in  6  gate box outputs: [0]=and, [1]=or, [2]=nand, [3]=nor, [4]=xor, [5]=xnor
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep completion
- `pass`  out  1  last sweep had zero mismatches; valid from `done` until the next accepted start
- `err_mask`  out  6  OR of mismatching `resp` bits over all vectors
- `fail_vec`  out  4  bit i set if vector i had any mismatch
- `err_count`  out  5  total mismatching bits over the sweep (0..24)

## Operation
- Vector i (0..3) drives `a` = i[1] and `b` = i[0]. Order is 00, 01, 10, 11.
- Expected value for vector (a,b): {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b}, listed as bits [5:0].
- FSM states:
  - IDLE: `a` = `b` = 0. `start`=1 goes to RUN.
  - RUN: walks the four vectors.
  - DONE: lasts exactly one cycle. `start`=1 goes to RUN; otherwise the FSM goes to IDLE.
- Start acceptance (IDLE or DONE with `start`=1), at that edge:
  - clear `err_mask`, `fail_vec`, `err_count` and `pass`
  - vector index = 0, settle counter = 0
  - drive `a`,`b` = vector 0
  - `busy` = 1
- In RUN:
  - The settle counter increments every cycle.
  - On the edge where the counter equals SETTLE_CYCLES-1:
    - sample `resp` and compute mismatch = `resp` ^ expected(current vector)
    - OR mismatch into `err_mask`
    - set `fail_vec`[index] if mismatch ≠ 0
    - add popcount(mismatch) to `err_count`
    - reset the counter to 0
  - If index < 3, advance the index and drive the next vector on that same edge.
  - If index = 3, go to DONE:
    - `a` = `b` = 0, `busy` = 0, `done` = 1
    - `pass` = (final `err_mask` == 0), including this last vector's mismatch
- `start` while in RUN is ignored and has no effect on counters or results.
- `err_count` saturation is not needed, because the maximum is 24 and fits in 5 bits.
- Results hold their values in IDLE until the next accepted start.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0
  - `err_mask`=0, `fail_vec`=0, `err_count`=0
  - FSM in IDLE, counters 0
- All outputs are registered. There are no combinational paths from `resp` or `start` to outputs.
- Start accepted at edge k:
  - Vector i is driven from edge k+i·SETTLE_CYCLES.
  - Vector i is sampled at edge k+(i+1)·SETTLE_CYCLES.
- Sweep latency: `done`=1 in the cycle after edge k+4·SETTLE_CYCLES. `busy`=1 for exactly 4·SETTLE_CYCLES cycles.
- With SETTLE_CYCLES=1, the gate box's combinational output must be valid within one clock period.
- `rst` mid-sweep:
  - Aborts the sweep immediately and all outputs take their reset values.
  - No `done` pulse is produced.
  - After `rst` deasserts, the FSM waits in IDLE for a new `start`.
- `start` held high continuously: sweeps run back-to-back. DONE lasts one cycle before each restart, and results clear on each restart edge.

## Test plan
- Ideal gate model on `resp`, SETTLE_CYCLES=1, 1-cycle `start` pulse -> `a`,`b` go 00,01,10,11 on consecutive cycles; `done` after 4 busy cycles; `pass`=1, `err_mask`=0, `fail_vec`=0, `err_count`=0.
- `resp`[4] (xor) stuck at 0 -> `pass`=0, `err_mask`=6'b010000, `fail_vec`=4'b0110, `err_count`=2.
- `resp` forced to all-ones -> `err_mask`=6'b111111, `fail_vec`=4'b1111, `err_count`=12.
- SETTLE_CYCLES=3 with ideal model -> each vector held 3 cycles; `busy` high 12 cycles; `done` in the cycle after edge k+12; `pass`=1.
- `start` pulsed again mid-sweep, then `rst` asserted while on vector 2 -> the second start has no effect; on `rst`, outputs go to reset values at once and no `done` pulse occurs; a later `start` runs a full clean sweep.
- `start` held high across two sweeps with a fault injected only during the first -> second sweep ends with `pass`=1 and cleared `err_mask`/`fail_vec`/`err_count`.
